// File: rtl/image_link_pkg.sv
// Shared definitions for the UART image link (sender and receiver sides).
package image_link_pkg;

    // Default two-byte frame sync header.
    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    // Position of each colour byte inside a pixel triplet.
    localparam logic [1:0] IDX_R = 2'd0;
    localparam logic [1:0] IDX_G = 2'd1;
    localparam logic [1:0] IDX_B = 2'd2;

    // Frame-level link state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT0,
        ST_HUNT1,
        ST_PIXEL,
        ST_DRAIN,
        ST_DONE
    } link_state_t;

    // Pack three colour bytes into one pixel word {R,G,B}.
    function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/rgb_pixel_assembler.sv
// Collects R,G,B bytes into a 24-bit pixel and strobes on the blue byte.
module rgb_pixel_assembler
    import image_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        done,
    output logic [23:0] word
);

    logic [1:0] idx;
    logic [7:0] r_q;
    logic [7:0] g_q;

    // Byte index and colour latches; clear discards any partial pixel.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            idx <= IDX_R;
            r_q <= '0;
            g_q <= '0;
        end else if (clear) begin
            idx <= IDX_R;
        end else if (byte_valid) begin
            case (idx)
                IDX_R: begin
                    r_q <= byte_data;
                    idx <= IDX_G;
                end
                IDX_G: begin
                    g_q <= byte_data;
                    idx <= IDX_B;
                end
                default: idx <= IDX_R;
            endcase
        end
    end

    // The blue byte completes the pixel combinationally; the caller registers it.
    assign done = byte_valid && !clear && (idx == IDX_B);
    assign word = pack_rgb(r_q, g_q, byte_data);

endmodule

// File: rtl/image_receiver.sv
// UART-side frame receiver: sync hunt, RGB assembly, raster tagging, pixel write port.
module image_receiver
    import image_link_pkg::*;
#(
    parameter int         WIDTH          = 640,
    parameter int         HEIGHT         = 480,
    parameter logic [7:0] SYNC0          = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1          = SYNC1_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic                      rdy,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [23:0]               pix_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic                      frame_done,
    output logic                      err_overrun,
    output logic                      err_timeout
);

    localparam int X_W   = $clog2(WIDTH);
    localparam int Y_W   = $clog2(HEIGHT);
    localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [X_W-1:0]   X_LAST   = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH * HEIGHT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    link_state_t      state;
    link_state_t      state_next;
    logic [CNT_W-1:0] pix_cnt;
    logic [X_W-1:0]   cur_x;
    logic [Y_W-1:0]   cur_y;
    logic [GAP_W-1:0] gap_cnt;

    logic        start;
    logic        abort;
    logic        gap_active;
    logic        timeout;
    logic        accept;
    logic        byte_valid;
    logic        asm_clear;
    logic        px_done;
    logic [23:0] px_word;

    assign start      = (state == ST_IDLE) && en;
    assign abort      = !en && (state != ST_IDLE) && (state != ST_DONE);
    assign gap_active = (state == ST_HUNT1) || (state == ST_PIXEL);
    // Counter value GAP_LAST plus one more idle cycle means TIMEOUT_CYCLES reached.
    assign timeout    = en && gap_active && !rx_valid && (gap_cnt == GAP_LAST);
    assign accept     = pix_valid && pix_ready;
    assign byte_valid = rx_valid && en && (state == ST_PIXEL);
    // Outside PIXEL the assembler always sits at the R byte with nothing pending.
    assign asm_clear  = (state != ST_PIXEL);

    assign rdy        = (state == ST_IDLE);
    assign frame_done = (state == ST_DONE);

    rgb_pixel_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (byte_valid),
        .byte_data  (rx_data),
        .done       (px_done),
        .word       (px_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic: en drop aborts, then timeout, then byte-driven progress.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (en) state_next = ST_HUNT0;
                ST_HUNT0: if (rx_valid && rx_data == SYNC0) state_next = ST_HUNT1;
                ST_HUNT1: begin
                    if (timeout)                          state_next = ST_HUNT0;
                    else if (rx_valid && rx_data == SYNC1) state_next = ST_PIXEL;
                    else if (rx_valid && rx_data != SYNC0) state_next = ST_HUNT0;
                end
                ST_PIXEL: begin
                    if (timeout)                            state_next = ST_HUNT0;
                    else if (px_done && pix_cnt == CNT_LAST) state_next = ST_DRAIN;
                end
                // The slot empties this edge if it is already empty or being accepted.
                ST_DRAIN: if (!pix_valid || pix_ready) state_next = ST_DONE;
                ST_DONE:  if (!en) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Inter-byte gap counter, running only while a header or frame is in progress.
    always_ff @(posedge clk) begin
        if (!rst_n || !gap_active || rx_valid || timeout) gap_cnt <= '0;
        else                                              gap_cnt <= gap_cnt + GAP_W'(1);
    end

    // Raster position of the next pixel to complete; advances even when a pixel is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || start || timeout) begin
            pix_cnt <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else if (px_done) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
            if (cur_x == X_LAST) begin
                cur_x <= '0;
                cur_y <= (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
            end else begin
                cur_x <= cur_x + X_W'(1);
            end
        end
    end

    // One-deep output slot: load when free or being accepted, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else if (start) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else if (abort) begin
            pix_valid <= 1'b0;
        end else if (px_done && (!pix_valid || pix_ready)) begin
            pix_valid <= 1'b1;
            pix_data  <= px_word;
            pix_x     <= cur_x;
            pix_y     <= cur_y;
        end else if (accept) begin
            pix_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared only when a new frame request starts.
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (timeout)                             err_timeout <= 1'b1;
            if (px_done && pix_valid && !pix_ready) err_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_image_receiver.sv
// Scoreboard bench for image_receiver: nominal frame, sync hunt, stall, timeout, abort, reset.
module tb_image_receiver;

    localparam int WIDTH          = 4;
    localparam int HEIGHT         = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int X_W            = $clog2(WIDTH);
    localparam int Y_W            = $clog2(HEIGHT);

    typedef struct packed {
        logic [23:0]    data;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           rdy;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [23:0]    pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           frame_done;
    logic           err_overrun;
    logic           err_timeout;

    pix_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    int   exp_x  = 0;
    int   exp_y  = 0;

    image_receiver #(
        .WIDTH          (WIDTH),
        .HEIGHT         (HEIGHT),
        .SYNC0          (8'hA5),
        .SYNC1          (8'h5A),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rdy         (rdy),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_done  (frame_done),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_header();
        send_byte(8'hA5);
        send_byte(8'h5A);
    endtask

    task automatic reset_model();
        exp_x = 0;
        exp_y = 0;
    endtask

    // keep=1: the pixel is expected to reach the sink; the raster model advances either way.
    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input bit keep);
        pix_t p;
        send_byte(r);
        send_byte(g);
        if (keep) begin
            p.data = {r, g, b};
            p.x    = X_W'(exp_x);
            p.y    = Y_W'(exp_y);
            sb.push_back(p);
        end
        send_byte(b);
        if (exp_x == WIDTH - 1) begin
            exp_x = 0;
            exp_y = (exp_y + 1) % HEIGHT;
        end else begin
            exp_x++;
        end
    endtask

    // Sink monitor: every accepted pixel is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && pix_valid && pix_ready) begin
            check("pix_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                pix_t e;
                e = sb.pop_front();
                check("pix_data", pix_data, e.data);
                check("pix_x", pix_x, e.x);
                check("pix_y", pix_y, e.y);
                n_acc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        pix_ready = 1'b1;
        repeat (2) tick();

        // Reset state.
        check("rst_rdy", rdy, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_err_timeout", err_timeout, 0);

        // Nominal frame: 8 pixels from bytes 0x01..0x18.
        rst_n = 1'b1;
        en    = 1'b1;
        reset_model();
        tick();
        check("nom_rdy_low", rdy, 0);
        send_header();
        for (int i = 0; i < WIDTH * HEIGHT; i++)
            send_pixel(8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3), 1'b1);
        check("nom_last_valid", pix_valid, 1);
        check("nom_done_early", frame_done, 0);
        tick();
        check("nom_frame_done", frame_done, 1);
        check("nom_valid_clear", pix_valid, 0);
        check("nom_count", n_acc, WIDTH * HEIGHT);
        check("nom_sb_empty", sb.size(), 0);
        en = 1'b0;
        tick();
        check("nom_rdy_back", rdy, 1);
        check("nom_done_clear", frame_done, 0);

        // Sync hunt through garbage and a repeated SYNC0.
        en = 1'b1;
        reset_model();
        tick();
        send_byte(8'h00); check("hunt_no_pix0", pix_valid, 0);
        send_byte(8'hA5); check("hunt_no_pix1", pix_valid, 0);
        send_byte(8'hA5); check("hunt_no_pix2", pix_valid, 0);
        send_byte(8'h5A); check("hunt_no_pix3", pix_valid, 0);
        send_pixel(8'h11, 8'h22, 8'h33, 1'b1);
        tick();
        check("hunt_sb_empty", sb.size(), 0);

        // Abort mid-pixel.
        send_byte(8'h44);
        en = 1'b0;
        tick();
        check("abort_rdy", rdy, 1);
        check("abort_valid", pix_valid, 0);

        // Stall: first pixel held, second dropped, third lands at (2,0).
        en = 1'b1;
        reset_model();
        tick();
        pix_ready = 1'b0;
        send_header();
        send_pixel(8'h01, 8'h02, 8'h03, 1'b1);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b0);
        check("stall_overrun", err_overrun, 1);
        check("stall_valid", pix_valid, 1);
        check("stall_held_data", pix_data, 32'h010203);
        check("stall_held_x", pix_x, 0);
        pix_ready = 1'b1;
        tick();
        send_pixel(8'h07, 8'h08, 8'h09, 1'b1);
        tick();
        check("stall_sb_empty", sb.size(), 0);
        en = 1'b0;
        tick();
        check("stall_abort_valid", pix_valid, 0);
        check("stall_flag_kept", err_overrun, 1);
        en = 1'b1;
        tick();
        check("stall_flag_cleared", err_overrun, 0);

        // Timeout after a partial pixel, then a clean resync.
        reset_model();
        send_header();
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (12) tick();
        check("tmo_not_yet", err_timeout, 0);
        repeat (6) tick();
        check("tmo_flag", err_timeout, 1);
        check("tmo_no_pix", pix_valid, 0);
        reset_model();
        send_header();
        send_pixel(8'h44, 8'h55, 8'h66, 1'b1);
        tick();
        check("tmo_sb_empty", sb.size(), 0);

        // Reset mid-frame with a held pixel and both flags set.
        pix_ready = 1'b0;
        send_pixel(8'h77, 8'h88, 8'h99, 1'b0);
        send_pixel(8'hAA, 8'hBB, 8'hCC, 1'b0);
        check("pre_rst_valid", pix_valid, 1);
        check("pre_rst_data", pix_data, 32'h778899);
        check("pre_rst_x", pix_x, 1);
        check("pre_rst_overrun", err_overrun, 1);
        check("pre_rst_timeout", err_timeout, 1);
        send_byte(8'h12);
        rst_n = 1'b0;
        tick();
        check("mid_rst_rdy", rdy, 1);
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_x", pix_x, 0);
        check("mid_rst_y", pix_y, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_overrun", err_overrun, 0);
        check("mid_rst_timeout", err_timeout, 0);
        en        = 1'b0;
        rst_n     = 1'b1;
        pix_ready = 1'b1;
        tick();
        check("post_rst_rdy", rdy, 1);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
UART-side frame receiver. It is the inbound counterpart of the pixel-to-UART sender.
- Hunts for a 2-byte sync header in the UART RX byte stream.
- Assembles each following R,G,B byte triplet into one 24-bit pixel tagged with raster coordinates.
- Presents pixels on a valid/ready write port to the frame-buffer / SDRAM write-side FIFO.
- Uses the same rdy/en frame handshake as the sender.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles between rx bytes once the header has started.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  frame request; held high for the whole frame.
- rdy  out  1  high only in IDLE.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- pix_data  out  24  {R[23:16],G[15:8],B[7:0]}.
- pix_valid  out  1  pix_data and pix_x/pix_y are valid.
- pix_ready  in  1  sink accepts the pixel when pix_valid && pix_ready.
- pix_x  out  $clog2(WIDTH)  column of pix_data.
- pix_y  out  $clog2(HEIGHT)  row of pix_data.
- frame_done  out  1  high in DONE.
- err_overrun  out  1  sticky: a pixel was dropped because the sink stalled.
- err_timeout  out  1  sticky: inter-byte gap timeout occurred.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state IDLE; rdy=1.
  - pix_valid=0, pix_data=0, pix_x=0, pix_y=0.
  - frame_done=0, err_overrun=0, err_timeout=0.
  - Byte index, pixel counter and gap counter all 0.
- rx_valid has no backpressure; a byte is never stalled, only consumed or discarded.
- States:
  - IDLE:
    - rdy=1; rx bytes are ignored.
    - en=1 -> HUNT0. On this transition, clear err flags, counters and pix_x/pix_y.
  - HUNT0:
    - rx byte == SYNC0 -> HUNT1.
    - Any other byte is discarded.
    - Gap timer is inactive.
  - HUNT1:
    - Byte == SYNC1 -> PIXEL.
    - Byte == SYNC0 -> stay in HUNT1.
    - Any other byte -> HUNT0.
  - PIXEL:
    - Byte index 0 latches R, index 1 latches G, index 2 completes the pixel.
    - Index wraps 2 -> 0.
  - DRAIN:
    - Entered when the WIDTH*HEIGHT-th pixel completes.
    - rx bytes are ignored.
    - Go to DONE once pix_valid=0, i.e. the last pixel has been accepted.
  - DONE:
    - frame_done=1.
    - Stay while en=1; en=0 -> IDLE.
- Pixel output:
  - pix_valid rises on the clk edge after the third-byte rx_valid, so latency is 1 cycle.
  - pix_data, pix_x and pix_y hold stable until accepted.
  - Accept (pix_valid && pix_ready) with no new pixel completing -> pix_valid=0 next cycle.
  - Accept and a new completion in the same cycle -> load the new pixel; pix_valid stays 1.
  - Completion while pix_valid=1 && pix_ready=0:
    - The new pixel is dropped and err_overrun=1.
    - The pixel counter and coordinates still advance, so raster alignment is preserved.
- Coordinates:
  - Raster order. x increments per completed pixel.
  - At x==WIDTH-1, x wraps to 0 and y increments.
  - Pixel counter is $clog2(WIDTH*HEIGHT+1) bits wide.
- Gap timeout:
  - Active in HUNT1 and PIXEL.
  - Counter clears on each rx_valid and otherwise increments.
  - When it reaches TIMEOUT_CYCLES: err_timeout=1, go to HUNT0, clear byte index, pixel counter and coordinates.
  - A pending output pixel stays valid until accepted.
- en=0 in any state other than IDLE/DONE:
  - Abort to IDLE next cycle.
  - pix_valid cleared, partial bytes discarded.
  - Err flags keep their values until the next IDLE->HUNT0 transition.
- rst_n low mid-frame: full reset next edge, as above.

Decomposition:
- Package image_link_pkg, shared with the sender:
  - SYNC0/SYNC1 defaults.
  - Byte-index constants IDX_R/IDX_G/IDX_B.
  - State enum.
  - Pixel packing helper for {R,G,B}.
- Sub-module rgb_pixel_assembler:
  - Holds the byte index and the R/G latches.
  - Emits a completion strobe and the 24-bit word.
  - Has a synchronous clear.

Test Plan (WIDTH=4, HEIGHT=2, TIMEOUT_CYCLES=16, pix_ready=1 unless stated):
- Nominal frame: en=1; rx 0xA5,0x5A, then 24 bytes 0x01..0x18 -> 8 pixels.
  - First pixel 0x010203 at (0,0); fifth pixel 0x0D0E0F at (0,1); last 0x161718 at (3,1).
  - frame_done=1 one cycle after the last accept; en=0 -> rdy=1.
- Sync hunt: rx 0x00,0xA5,0xA5,0x5A,0x11,0x22,0x33 -> first pixel 0x112233 at (0,0); no pixel before the header completes.
- Stall: hold pix_ready=0 across two completed pixels.
  - err_overrun=1; pixel 1 is held on pix_data.
  - After release, the next delivered pixel is at (2,0).
- Timeout: after the header plus 0x11,0x22, idle 16 cycles.
  - err_timeout=1, state HUNT0.
  - A new header plus 0x44,0x55,0x66 -> pixel 0x445566 at (0,0).
- Abort/reset: drop en mid-pixel -> IDLE next cycle, pix_valid=0; re-enable -> flags cleared. Same sequence with rst_n=0 instead of en=0 -> all outputs at reset values.
